// File: rtl/gsim_pkg.sv
// gsim_pkg: shared sizes, coefficients, state encoding and output rounding for the Gauss-Seidel solver
package gsim_pkg;
  localparam int N = 16;
  localparam int CW = $clog2(N);
  localparam int N_ITER = 256;
  localparam int IFRAC = 20;
  localparam int BW = 16;
  localparam int XW = 40;
  localparam int AW = 48;
  localparam int OW = 32;
  localparam logic signed [AW-1:0] C0 = 20;
  localparam logic signed [AW-1:0] C1 = 13;
  localparam logic signed [AW-1:0] C2 = 6;
  localparam logic signed [AW-1:0] C3 = 1;
  localparam logic signed [AW-1:0] RND = 10;
  localparam int OFF [6] = '{-3, -2, -1, 1, 2, 3};
  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;
  typedef logic signed [XW-1:0] xval_t;
  localparam xval_t XMAX = {1'b0, {(XW-1){1'b1}}};
  localparam xval_t XMIN = {1'b1, {(XW-1){1'b0}}};
  localparam logic signed [XW:0] OMAX = (XW+1)'(32'sh7FFFFFFF);
  localparam logic signed [XW:0] OMIN = (XW+1)'(32'sh80000000);
  // Drops IFRAC-16 fraction bits, rounding half away from zero, then clamps to Q16.16.
  function automatic logic [OW-1:0] to_q16(input xval_t v);
    logic signed [XW:0] e, a, s;
    e = (XW+1)'(v);
    a = v[XW-1] ? -e : e;
    a = (a + (XW+1)'(1 << (IFRAC - 17))) >>> (IFRAC - 16);
    s = v[XW-1] ? -a : a;
    return s > OMAX ? OMAX[OW-1:0] : s < OMIN ? OMIN[OW-1:0] : OW'(s);
  endfunction
endpackage

// File: rtl/gsim_if.sv
// gsim_if: b-sample input stream and solution output stream of the solver
interface gsim_if;
  import gsim_pkg::*;
  logic in_en;
  logic signed [BW-1:0] b_in;
  logic out_valid;
  logic [OW-1:0] x_out;
  modport master (output in_en, b_in, input out_valid, x_out);
  modport slave (input in_en, b_in, output out_valid, x_out);
endinterface

// File: rtl/gsim_row_update.sv
// gsim_row_update: one Gauss-Seidel row update, x_i = round((b_i - sum off-diagonal A_ij x_j) / 20)
module gsim_row_update
  import gsim_pkg::*;
(
  input  logic signed [BW-1:0] b_i,
  input  xval_t                xn [6],
  input  logic [5:0]           nv,
  output xval_t                x_new
);
  logic signed [AW-1:0] m [6];
  logic signed [AW-1:0] acc, mag, q, res;
  always_comb begin
    for (int k = 0; k < 6; k++) m[k] = nv[k] ? AW'(xn[k]) : '0;
    acc = (AW'(b_i) <<< IFRAC) + C1 * (m[2] + m[3]) - C2 * (m[1] + m[4]) + C3 * (m[0] + m[5]);
    mag = acc[AW-1] ? -acc : acc;
    q = (mag + RND) / C0;
    res = acc[AW-1] ? -q : q;
    x_new = res > AW'(XMAX) ? XMAX : res < AW'(XMIN) ? XMIN : xval_t'(res);
  end
endmodule

// File: rtl/gsim_solver.sv
// gsim_solver: loads 16 b samples, runs fixed Gauss-Seidel sweeps, streams 16 Q16.16 results
module gsim_solver
  import gsim_pkg::*;
#(
  parameter int ITERS = N_ITER
) (
  input logic   clk,
  input logic   reset,
  gsim_if.slave io
);
  localparam int IW = $clog2(ITERS + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] iter;
  logic signed [BW-1:0] b [N];
  xval_t x [N];
  xval_t nx [6];
  logic [5:0] nv;
  xval_t x_new;
  // cnt doubles as load index, row index and output index; modular offsets select neighbours.
  always_comb begin
    nv = '0;
    for (int k = 0; k < 6; k++) begin
      nv[k] = (int'(cnt) + OFF[k] >= 0) && (int'(cnt) + OFF[k] < N);
      nx[k] = x[cnt + CW'(OFF[k])];
    end
  end
  gsim_row_update u_row (
    .b_i  (b[cnt]),
    .xn   (nx),
    .nv   (nv),
    .x_new(x_new)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      iter <= '0;
      io.out_valid <= 1'b0;
      io.x_out <= '0;
      for (int k = 0; k < N; k++) begin
        b[k] <= '0;
        x[k] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          io.out_valid <= 1'b0;
          io.x_out <= '0;
          if (io.in_en) begin
            b[cnt] <= io.b_in;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(N - 1)) begin
              state <= CALC;
              iter <= '0;
              for (int k = 0; k < N; k++) x[k] <= '0;
            end
          end
        end
        CALC: begin
          x[cnt] <= x_new;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            iter <= iter + 1'b1;
            if (iter == IW'(ITERS - 1)) state <= OUT;
          end
        end
        OUT: begin
          io.out_valid <= 1'b1;
          io.x_out <= to_q16(x[cnt]);
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gsim_solver.sv
// tb_gsim_solver: random and directed problems checked against a plain-arithmetic Gauss-Seidel model
module tb_gsim_solver;
  logic clk = 0;
  logic reset = 1;
  gsim_if io ();
  gsim_solver dut (.clk(clk), .reset(reset), .io(io));
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int bq [16];
  int em [16];
  int got [16];
  int ref3 [16];
  int vec_ones [16] = '{12, -1, 5, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 5, -1, 12};

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int a_coef(input int i, input int j);
    int d = i > j ? i - j : j - i;
    return d == 0 ? 20 : d == 1 ? -13 : d == 2 ? 6 : d == 3 ? -1 : 0;
  endfunction

  // x_i := round_half_away((b_i*2^20 - sum_{j!=i} A_ij*x_j) / 20), clamped to 40-bit range
  task automatic model();
    longint xm [16];
    longint num, q, r;
    longint lim = 64'sd1 <<< 39;
    foreach (xm[i]) xm[i] = 0;
    for (int it = 0; it < 256; it++)
      for (int i = 0; i < 16; i++) begin
        num = longint'(bq[i]) * 1048576;
        for (int j = 0; j < 16; j++) if (j != i) num -= a_coef(i, j) * xm[j];
        q = num >= 0 ? (num + 10) / 20 : -((-num + 10) / 20);
        xm[i] = q > lim - 1 ? lim - 1 : q < -lim ? -lim : q;
      end
    for (int i = 0; i < 16; i++) begin
      r = xm[i] >= 0 ? (xm[i] + 8) / 16 : -((-xm[i] + 8) / 16);
      em[i] = r > 64'sd2147483647 ? 32'sh7FFFFFFF : r < -64'sd2147483648 ? 32'sh80000000 : int'(r);
    end
  endtask

  task automatic load_b(input int gap_max, input bit chk_idle);
    for (int i = 0; i < 16; i++) begin
      if (i > 0)
        repeat ($urandom_range(0, gap_max)) begin
          io.in_en = 0;
          io.b_in = 16'($urandom);
          @(posedge clk); #1;
        end
      io.in_en = 1;
      io.b_in = 16'(bq[i]);
      @(posedge clk); #1;
      if (i == 0 && chk_idle) begin
        chk("idle_valid", io.out_valid, 0);
        chk("idle_xout", io.x_out, 0);
      end
    end
    io.in_en = 0;
  endtask

  task automatic collect(input string tag, input bit noise);
    int n;
    for (n = 1; n <= 5000; n++) begin
      @(posedge clk); #1;
      if (io.out_valid) break;
      if (noise) begin
        io.in_en = 1;
        io.b_in = 16'($urandom);
      end
    end
    chk({tag, "_latency"}, n, 16 * 256 + 1);
    got[0] = $signed(io.x_out);
    for (int k = 1; k < 16; k++) begin
      @(posedge clk); #1;
      chk($sformatf("%s_valid%0d", tag, k), io.out_valid, 1);
      got[k] = $signed(io.x_out);
    end
    io.in_en = 0;
    for (int k = 0; k < 16; k++) chk($sformatf("%s_x%0d", tag, k), got[k], em[k]);
  endtask

  task automatic run(input string tag, input int gap_max, input bit noise, input bit chk_idle);
    model();
    load_b(gap_max, chk_idle);
    collect(tag, noise);
  endtask

  initial begin
    int hits;
    real ss, r;
    io.in_en = 0;
    io.b_in = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    chk("rst_valid", io.out_valid, 0);
    chk("rst_xout", io.x_out, 0);
    foreach (bq[i]) bq[i] = 0;
    run("t1", 0, 0, 0);
    bq = vec_ones;
    run("t2", 0, 0, 1);
    for (int k = 0; k < 16; k++)
      chk($sformatf("t2_near_one%0d", k), (got[k] >= 32'h0000FFFE && got[k] <= 32'h00010002), 1);
    foreach (bq[i]) bq[i] = int'($urandom_range(0, 16000)) - 8000;
    bq[3] = -32768;
    bq[10] = 32767;
    run("t3", 0, 0, 1);
    ref3 = got;
    ss = 0.0;
    for (int i = 0; i < 16; i++) begin
      r = -real'(bq[i]);
      for (int j = 0; j < 16; j++) r += a_coef(i, j) * (real'(got[j]) / 65536.0);
      ss += r * r;
    end
    chk("t3_resid_small", ss < 1e-5, 1);
    run("t4", 3, 0, 1);
    for (int k = 0; k < 16; k++) chk($sformatf("t4_same%0d", k), got[k], ref3[k]);
    foreach (bq[i]) bq[i] = int'($urandom_range(0, 2000)) - 1000;
    load_b(0, 1);
    repeat (300) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    hits = 0;
    repeat (4300) begin
      @(posedge clk); #1;
      if (io.out_valid) hits++;
    end
    chk("t5_no_out_after_rst", hits, 0);
    bq = vec_ones;
    run("t5", 0, 1, 0);
    run("t6a", 0, 0, 1);
    foreach (bq[i]) bq[i] = 0;
    run("t6b", 0, 0, 1);
    @(posedge clk); #1;
    chk("end_valid", io.out_valid, 0);
    chk("end_xout", io.x_out, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
